// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: one state per cycle, Moore outputs plus
// mem_ready/zero Mealy terms, shared-memory handshake stalls.
//
// state   | meaning
// RESET   | post-reset idle, all outputs low
// FETCH   | read instruction at PC, PC+4 when memory ready
// DECODE  | register read, branch target computed into ALUOut
// MEMADR  | lw/sw effective address
// MEMRD   | lw data read, waits for memory
// MEMWB   | lw writeback from MDR
// MEMWR   | sw data write, waits for memory
// EXECUTE | R-type ALU operation
// ALUWB   | R-type writeback to rd
// BRANCH  | beq compare, PC <= ALUOut when zero
// ADDIEX  | addi ALU operation
// ADDIWB  | addi writeback to rt
// JUMP    | PC <= jump target
// HALT    | trapped on illegal opcode until reset
module multicycle_controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluctrl,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12,
    S_HALT    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_d;
  logic   pcwrite;
  logic   branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluctrl    = 3'b000;
    pcsrc      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        alusrcb = 2'b01;
        aluctrl = ALU_ADD;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        aluctrl = ALU_ADD;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluctrl = ALU_ADD;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        // strobe stays high through the whole stall so memory sees a stable request
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        case (funct)
          6'b100000: aluctrl = ALU_ADD;
          6'b100010: aluctrl = ALU_SUB;
          6'b100100: aluctrl = ALU_AND;
          6'b100101: aluctrl = ALU_OR;
          6'b101010: aluctrl = ALU_SLT;
          default:   aluctrl = ALU_AND;
        endcase
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        aluctrl    = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluctrl = ALU_ADD;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase

    pcen = pcwrite | (branch & zero);
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: two instances (no trap / trap)
// share stimulus; expectations are hand-derived state walks and output values.
module tb_multicycle_controller;

  logic       clk, rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;

  logic       iord0, memwrite0, irwrite0, regdst0, memtoreg0, regwrite0, alusrca0;
  logic [1:0] alusrcb0, pcsrc0;
  logic [2:0] aluctrl0;
  logic       pcen0, instr_done0, illegal0;
  logic [3:0] state0;

  logic       iord1, memwrite1, irwrite1, regdst1, memtoreg1, regwrite1, alusrca1;
  logic [1:0] alusrcb1, pcsrc1;
  logic [2:0] aluctrl1;
  logic       pcen1, instr_done1, illegal1;
  logic [3:0] state1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0]  cap_alu, cap_wb, cap_pc;
  logic [19:0] seq;

  wire [17:0] outs0 = {iord0, memwrite0, irwrite0, regdst0, memtoreg0, regwrite0, alusrca0,
                       alusrcb0, aluctrl0, pcsrc0, pcen0, instr_done0, illegal0};
  wire [17:0] outs1 = {iord1, memwrite1, irwrite1, regdst1, memtoreg1, regwrite1, alusrca1,
                       alusrcb1, aluctrl1, pcsrc1, pcen1, instr_done1, illegal1};

  multicycle_controller #(.ILLEGAL_TRAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord0), .memwrite(memwrite0), .irwrite(irwrite0), .regdst(regdst0),
    .memtoreg(memtoreg0), .regwrite(regwrite0), .alusrca(alusrca0), .alusrcb(alusrcb0),
    .aluctrl(aluctrl0), .pcsrc(pcsrc0), .pcen(pcen0), .instr_done(instr_done0),
    .illegal(illegal0), .state(state0)
  );

  multicycle_controller #(.ILLEGAL_TRAP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord1), .memwrite(memwrite1), .irwrite(irwrite1), .regdst(regdst1),
    .memtoreg(memtoreg1), .regwrite(regwrite1), .alusrca(alusrca1), .alusrcb(alusrcb1),
    .aluctrl(aluctrl1), .pcsrc(pcsrc1), .pcen(pcen1), .instr_done(instr_done1),
    .illegal(illegal1), .state(state1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs one instruction on dut0 from FETCH back to FETCH, stalling mem_ready
  // for fs cycles in FETCH and ms cycles in MEMRD/MEMWR.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fs, input int ms,
                           output int cyc, output int n_irw, output int n_done,
                           output int n_rw_early, output int n_ill);
    bit left;
    op = o; funct = f; zero = z;
    cyc = 0; n_irw = 0; n_done = 0; n_rw_early = 0; n_ill = 0;
    cap_alu = 'x; cap_wb = 'x; cap_pc = 'x; seq = '0;
    left = 1'b0;
    for (int i = 0; i < 50; i++) begin
      mem_ready = 1'b1;
      if (state0 == 4'd1 && fs > 0) begin mem_ready = 1'b0; fs--; end
      if ((state0 == 4'd4 || state0 == 4'd6) && ms > 0) begin mem_ready = 1'b0; ms--; end
      #1;
      seq = {seq[15:0], state0};
      if (irwrite0) n_irw++;
      if (instr_done0) n_done++;
      if (illegal0) n_ill++;
      if (regwrite0 && state0 != 4'd5 && state0 != 4'd8 && state0 != 4'd11) n_rw_early++;
      if (state0 == 4'd7) cap_alu = aluctrl0;
      if (state0 == 4'd5 || state0 == 4'd8 || state0 == 4'd11) cap_wb = {regwrite0, memtoreg0, regdst0};
      if (state0 == 4'd9 || state0 == 4'd12) cap_pc = {pcen0, pcsrc0};
      cyc++;
      tick();
      if (state0 != 4'd1) left = 1'b1;
      if (state0 == 4'd1 && left) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op = 6'b100011; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (state0 !== 4'd0) begin n_fail++; $display("FAIL reset_state0 got %0d want 0", state0); end
    n_checks++;
    if (outs0 !== '0) begin n_fail++; $display("FAIL reset_outs0 got %h want 0", outs0); end
    n_checks++;
    if (outs1 !== '0 || state1 !== 4'd0) begin n_fail++; $display("FAIL reset_dut1 got %h/%0d want 0/0", outs1, state1); end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (state0 !== 4'd1) begin n_fail++; $display("FAIL reset_release got %0d want 1", state0); end
  endtask

  task automatic test_lw();
    int cyc, irw, dn, rwe, il;
    run_instr(6'b100011, 6'b0, 1'b0, 0, 0, cyc, irw, dn, rwe, il);
    n_checks++;
    if (cyc !== 5) begin n_fail++; $display("FAIL lw_cycles got %0d want 5", cyc); end
    n_checks++;
    if (seq !== 20'h12345) begin n_fail++; $display("FAIL lw_states got %h want 12345", seq); end
    n_checks++;
    if (cap_wb !== 3'b110) begin n_fail++; $display("FAIL lw_wb got %b want 110", cap_wb); end
    n_checks++;
    if (dn !== 1) begin n_fail++; $display("FAIL lw_done got %0d want 1", dn); end
  endtask

  task automatic test_lw_stall();
    int cyc, irw, dn, rwe, il;
    run_instr(6'b100011, 6'b0, 1'b0, 2, 3, cyc, irw, dn, rwe, il);
    n_checks++;
    if (cyc !== 10) begin n_fail++; $display("FAIL lw_stall_cycles got %0d want 10", cyc); end
    n_checks++;
    if (irw !== 1) begin n_fail++; $display("FAIL lw_stall_irwrite got %0d want 1", irw); end
    n_checks++;
    if (rwe !== 0) begin n_fail++; $display("FAIL lw_stall_early_regwrite got %0d want 0", rwe); end
  endtask

  task automatic test_rtype();
    int cyc, irw, dn, rwe, il;
    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, cyc, irw, dn, rwe, il);
    n_checks++;
    if (cyc !== 4) begin n_fail++; $display("FAIL slt_cycles got %0d want 4", cyc); end
    n_checks++;
    if (cap_alu !== 3'b111) begin n_fail++; $display("FAIL slt_aluctrl got %b want 111", cap_alu); end
    n_checks++;
    if (cap_wb !== 3'b101) begin n_fail++; $display("FAIL slt_wb got %b want 101", cap_wb); end
    run_instr(6'b000000, 6'b100111, 1'b0, 0, 0, cyc, irw, dn, rwe, il);
    n_checks++;
    if (cap_alu !== 3'b000) begin n_fail++; $display("FAIL nor_aluctrl got %b want 000", cap_alu); end
    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0, cyc, irw, dn, rwe, il);
    n_checks++;
    if (cap_alu !== 3'b110) begin n_fail++; $display("FAIL sub_aluctrl got %b want 110", cap_alu); end
    run_instr(6'b000000, 6'b100101, 1'b0, 0, 0, cyc, irw, dn, rwe, il);
    n_checks++;
    if (cap_alu !== 3'b001) begin n_fail++; $display("FAIL or_aluctrl got %b want 001", cap_alu); end
  endtask

  task automatic test_branch_jump();
    int cyc, irw, dn, rwe, il;
    run_instr(6'b000100, 6'b0, 1'b1, 0, 0, cyc, irw, dn, rwe, il);
    n_checks++;
    if (cyc !== 3 || cap_pc !== 3'b101) begin n_fail++; $display("FAIL beq_taken got %0d/%b want 3/101", cyc, cap_pc); end
    run_instr(6'b000100, 6'b0, 1'b0, 0, 0, cyc, irw, dn, rwe, il);
    n_checks++;
    if (cyc !== 3 || cap_pc !== 3'b001) begin n_fail++; $display("FAIL beq_not_taken got %0d/%b want 3/001", cyc, cap_pc); end
    run_instr(6'b000010, 6'b0, 1'b0, 0, 0, cyc, irw, dn, rwe, il);
    n_checks++;
    if (cyc !== 3 || cap_pc !== 3'b110 || seq !== 20'h0012C) begin
      n_fail++; $display("FAIL jump got %0d/%b/%h want 3/110/0012c", cyc, cap_pc, seq);
    end
  endtask

  task automatic test_sw_addi();
    int cyc, irw, dn, rwe, il;
    run_instr(6'b101011, 6'b0, 1'b0, 0, 0, cyc, irw, dn, rwe, il);
    n_checks++;
    if (cyc !== 4 || seq !== 20'h01236 || dn !== 1) begin
      n_fail++; $display("FAIL sw got %0d/%h/%0d want 4/01236/1", cyc, seq, dn);
    end
    run_instr(6'b001000, 6'b0, 1'b0, 0, 0, cyc, irw, dn, rwe, il);
    n_checks++;
    if (cyc !== 4 || seq !== 20'h012AB || cap_wb !== 3'b100) begin
      n_fail++; $display("FAIL addi got %0d/%h/%b want 4/012ab/100", cyc, seq, cap_wb);
    end
  endtask

  task automatic test_illegal();
    int cyc, irw, dn, rwe, il;
    run_instr(6'b111111, 6'b0, 1'b0, 0, 0, cyc, irw, dn, rwe, il);
    n_checks++;
    if (cyc !== 2 || il !== 1) begin n_fail++; $display("FAIL illegal_notrap got %0d/%0d want 2/1", cyc, il); end
    repeat (3) tick();
    n_checks++;
    if (state1 !== 4'd13 || outs1 !== '0) begin
      n_fail++; $display("FAIL illegal_trap got %0d/%h want 13/0", state1, outs1);
    end
  endtask

  task automatic test_sw_reset();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    tick();
    op = 6'b101011; mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    tick();
    #1;
    n_checks++;
    if (state0 !== 4'd6 || memwrite0 !== 1'b1 || iord0 !== 1'b1) begin
      n_fail++; $display("FAIL sw_hold got %0d/%b/%b want 6/1/1", state0, memwrite0, iord0);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (memwrite0 !== 1'b0 || state0 !== 4'd0 || outs0 !== '0) begin
      n_fail++; $display("FAIL sw_reset got %b/%0d/%h want 0/0/0", memwrite0, state0, outs0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (state0 !== 4'd1 || state1 !== 4'd1) begin
      n_fail++; $display("FAIL sw_reset_release got %0d/%0d want 1/1", state0, state1);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lw_stall();
    test_rtype();
    test_branch_jump();
    test_sw_addi();
    test_illegal();
    test_sw_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
